// File: rtl/vga_config_loader_pkg.sv
// Shared VGA width parameters, timing-register address map and loader FSM
// encodings used by the configuration loader and its table ROM.
package vga_config_loader_pkg;

    // Shared VGA datapath widths.
    localparam int VGA_CONFIG_WIDTH = 4;
    localparam int VGA_DATA_WIDTH   = 4;
    localparam int VGA_COLOR_WIDTH  = 4;

    // Timing register address map of the VGA controller configuration port.
    localparam int ADDR_H_LEFT_MARGIN  = 0;
    localparam int ADDR_V_LEFT_MARGIN  = 1;
    localparam int ADDR_H_RIGHT_MARGIN = 2;
    localparam int ADDR_V_RIGHT_MARGIN = 3;
    localparam int ADDR_H_SYNC_PULSE   = 4;
    localparam int ADDR_V_SYNC_PULSE   = 5;
    localparam int ADDR_H_COUNT_MAX    = 6;
    localparam int ADDR_V_COUNT_MAX    = 7;
    localparam int NUM_TIMING_REGS     = 8;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } loader_state_e;

    // Counter/index width that can hold 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_config_rom.sv
// Combinational timing-register table: register index in, register value out.
// Indices outside the address map read as zero.
module vga_config_rom #(
    parameter int CONFIG_WIDTH = vga_config_loader_pkg::VGA_CONFIG_WIDTH,
    parameter int IDX_W        = 3,
    parameter logic [CONFIG_WIDTH-1:0] H_LEFT_MARGIN  = CONFIG_WIDTH'(1),
    parameter logic [CONFIG_WIDTH-1:0] V_LEFT_MARGIN  = CONFIG_WIDTH'(2),
    parameter logic [CONFIG_WIDTH-1:0] H_RIGHT_MARGIN = CONFIG_WIDTH'(7),
    parameter logic [CONFIG_WIDTH-1:0] V_RIGHT_MARGIN = CONFIG_WIDTH'(8),
    parameter logic [CONFIG_WIDTH-1:0] H_SYNC_PULSE   = CONFIG_WIDTH'(1),
    parameter logic [CONFIG_WIDTH-1:0] V_SYNC_PULSE   = CONFIG_WIDTH'(0),
    parameter logic [CONFIG_WIDTH-1:0] H_COUNT_MAX    = CONFIG_WIDTH'(10),
    parameter logic [CONFIG_WIDTH-1:0] V_COUNT_MAX    = CONFIG_WIDTH'(12)
) (
    input  logic [IDX_W-1:0]        idx_i,
    output logic [CONFIG_WIDTH-1:0] data_o
);
    import vga_config_loader_pkg::*;

    logic [31:0] idx_ext;

    // Address decode against the shared register map.
    always_comb begin
        idx_ext = 32'(idx_i);
        data_o  = '0;
        case (idx_ext)
            32'(ADDR_H_LEFT_MARGIN):  data_o = H_LEFT_MARGIN;
            32'(ADDR_V_LEFT_MARGIN):  data_o = V_LEFT_MARGIN;
            32'(ADDR_H_RIGHT_MARGIN): data_o = H_RIGHT_MARGIN;
            32'(ADDR_V_RIGHT_MARGIN): data_o = V_RIGHT_MARGIN;
            32'(ADDR_H_SYNC_PULSE):   data_o = H_SYNC_PULSE;
            32'(ADDR_V_SYNC_PULSE):   data_o = V_SYNC_PULSE;
            32'(ADDR_H_COUNT_MAX):    data_o = H_COUNT_MAX;
            32'(ADDR_V_COUNT_MAX):    data_o = V_COUNT_MAX;
            default:                  data_o = '0;
        endcase
    end

endmodule

// File: rtl/vga_config_loader.sv
// Walks the timing-register table and writes each entry to the VGA controller
// configuration port, one write per accepted cycle, with a per-write timeout.
//
// Handshake: a write is presented with c_valid=1 and c_addr/c_data held stable
// until the edge where c_valid and c_ready are both high; that edge completes
// the write. c_ready is ignored whenever c_valid is low.
//
// Note: rst_n is an active-HIGH synchronous reset despite its name.
module vga_config_loader #(
    parameter int CONFIG_WIDTH = vga_config_loader_pkg::VGA_CONFIG_WIDTH,
    parameter int NUM_REGS     = vga_config_loader_pkg::NUM_TIMING_REGS,
    parameter int TIMEOUT      = 64,
    parameter logic [CONFIG_WIDTH-1:0] H_LEFT_MARGIN  = CONFIG_WIDTH'(1),
    parameter logic [CONFIG_WIDTH-1:0] V_LEFT_MARGIN  = CONFIG_WIDTH'(2),
    parameter logic [CONFIG_WIDTH-1:0] H_RIGHT_MARGIN = CONFIG_WIDTH'(7),
    parameter logic [CONFIG_WIDTH-1:0] V_RIGHT_MARGIN = CONFIG_WIDTH'(8),
    parameter logic [CONFIG_WIDTH-1:0] H_SYNC_PULSE   = CONFIG_WIDTH'(1),
    parameter logic [CONFIG_WIDTH-1:0] V_SYNC_PULSE   = CONFIG_WIDTH'(0),
    parameter logic [CONFIG_WIDTH-1:0] H_COUNT_MAX    = CONFIG_WIDTH'(10),
    parameter logic [CONFIG_WIDTH-1:0] V_COUNT_MAX    = CONFIG_WIDTH'(12)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    c_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    import vga_config_loader_pkg::*;

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int CNT_W = idx_width(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    // State is kept as a named enum so checkers can bind to state_q directly.
    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CONFIG_WIDTH-1:0] rom_data;

    vga_config_rom #(
        .CONFIG_WIDTH   (CONFIG_WIDTH),
        .IDX_W          (IDX_W),
        .H_LEFT_MARGIN  (H_LEFT_MARGIN),
        .V_LEFT_MARGIN  (V_LEFT_MARGIN),
        .H_RIGHT_MARGIN (H_RIGHT_MARGIN),
        .V_RIGHT_MARGIN (V_RIGHT_MARGIN),
        .H_SYNC_PULSE   (H_SYNC_PULSE),
        .V_SYNC_PULSE   (V_SYNC_PULSE),
        .H_COUNT_MAX    (H_COUNT_MAX),
        .V_COUNT_MAX    (V_COUNT_MAX)
    ) u_rom (
        .idx_i  (idx_q),
        .data_o (rom_data)
    );

    // State, index and timeout counter registers; reset abandons any write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sequencing, acceptance and timeout detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ISSUE: begin
                if (c_ready) begin
                    // Acceptance takes priority over an expiring timeout.
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE, DONE and ERR all restart the sequence from index 0.
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Outputs decoded from state; address/data read zero outside ISSUE.
    always_comb begin
        c_valid = (state_q == ST_ISSUE);
        busy    = (state_q == ST_ISSUE);
        done    = (state_q == ST_DONE);
        error   = (state_q == ST_ERR);
        c_addr  = '0;
        c_data  = '0;
        if (state_q == ST_ISSUE) begin
            c_addr = CONFIG_WIDTH'(idx_q);
            c_data = rom_data;
        end
    end

endmodule

// File: tb/tb_vga_config_loader.sv
// Directed bench for vga_config_loader with default parameters.
module tb_vga_config_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       c_ready;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [3:0] c_data;
    logic       busy;
    logic       done;
    logic       error;

    int checks   = 0;
    int failures = 0;

    // Expected {addr, data} pairs in write order.
    logic [7:0] exp_q[$];
    logic [3:0] exp_table [8] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1, 4'd0, 4'd10, 4'd12};

    vga_config_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .c_valid (c_valid),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .c_ready (c_ready),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Driver helpers; all tasks start and end just after a falling edge.
    task automatic fill_exp();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), exp_table[i]});
    endtask

    task automatic pulse_start(input logic rdy);
        start   = 1'b1;
        c_ready = rdy;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; c_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_valid, busy, done, error, c_addr, c_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_held: got v/b/d/e=%b%b%b%b addr=%h data=%h required all 0",
                     c_valid, busy, done, error, c_addr, c_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_valid, busy, done, error, c_addr, c_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_release: got v/b/d/e=%b%b%b%b addr=%h data=%h required all 0",
                     c_valid, busy, done, error, c_addr, c_data);
        end
    endtask

    task automatic test_full_sequence();
        logic [7:0] e;
        fill_exp();
        pulse_start(1'b1);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (c_valid !== 1'b1 || busy !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL full_write%0d: got valid=%b busy=%b addr/data=%h required 1 1 %h",
                         k, c_valid, busy, {c_addr, c_data}, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL full_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL done_sticky: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
    endtask

    task automatic test_stall();
        logic [7:0] e;
        int stall = 0;
        int held  = 0;
        int cyc   = 0;
        fill_exp();
        pulse_start(1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_restart_clears_done: got done=%b busy=%b required 0 1", done, busy);
        end
        while (exp_q.size() > 0 && cyc < 60) begin
            e = exp_q[0];
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL stall_write: got valid=%b addr/data=%h required 1 %h",
                         c_valid, {c_addr, c_data}, e);
            end
            if (c_addr == 4'd3) held++;
            if (c_addr == 4'd3 && stall < 5) begin
                c_ready = 1'b0;
                stall++;
            end else begin
                c_ready = 1'b1;
                e = exp_q.pop_front();
            end
            @(negedge clk);
            cyc++;
        end
        c_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_complete: got %0d writes left required 0", exp_q.size());
        end
        checks++;
        if (held != 6) begin
            failures++;
            $display("FAIL stall_hold: got addr3 held %0d cycles required 6", held);
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL stall_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
    endtask

    task automatic test_timeout_boundary();
        logic [7:0] e;
        logic [3:0] last_addr = 4'hf;
        int stall = 0;
        int cyc   = 0;
        fill_exp();
        pulse_start(1'b0);
        while (exp_q.size() > 0 && cyc < 200) begin
            e = exp_q[0];
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL boundary_write: got valid=%b addr/data=%h required 1 %h",
                         c_valid, {c_addr, c_data}, e);
            end
            if (c_addr != last_addr) stall = 0;
            last_addr = c_addr;
            // 63 stalled cycles put the counter at its last value; accept then.
            if (c_addr <= 4'd1 && stall < 63) begin
                c_ready = 1'b0;
                stall++;
            end else begin
                c_ready = 1'b1;
                e = exp_q.pop_front();
            end
            @(negedge clk);
            cyc++;
        end
        c_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL boundary_complete: got %0d writes left required 0", exp_q.size());
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL boundary_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        int cnt = 0;
        int bad = 0;
        pulse_start(1'b0);
        while (c_valid === 1'b1 && cnt < 100) begin
            if ({c_addr, c_data} !== 8'h01) bad++;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 64) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d valid cycles required 64", cnt);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_addr_hold: got %0d cycles off addr0/data1 required 0", bad);
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b0001) begin
            failures++;
            $display("FAIL timeout_err: got d/b/v/e=%b%b%b%b required 0001", done, busy, c_valid, error);
        end
        c_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, busy, c_valid, error} !== 4'b0001) begin
            failures++;
            $display("FAIL err_sticky: got d/b/v/e=%b%b%b%b required 0001", done, busy, c_valid, error);
        end
        fill_exp();
        pulse_start(1'b1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_cleared: got error=%b busy=%b required 0 1", error, busy);
        end
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL retry_write%0d: got valid=%b addr/data=%h required 1 %h",
                         k, c_valid, {c_addr, c_data}, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL retry_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        int cyc = 0;
        fill_exp();
        pulse_start(1'b1);
        while (c_addr !== 4'd4 && cyc < 20) begin
            e = exp_q.pop_front();
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL rstmid_write: got valid=%b addr/data=%h required 1 %h",
                         c_valid, {c_addr, c_data}, e);
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (c_valid !== 1'b1 || c_addr !== 4'd4) begin
            failures++;
            $display("FAIL rstmid_reach4: got valid=%b addr=%h required 1 4", c_valid, c_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({c_valid, busy, done, error, c_addr, c_data} !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_idle: got v/b/d/e=%b%b%b%b addr=%h data=%h required all 0",
                     c_valid, busy, done, error, c_addr, c_data);
        end
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (c_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_no_reissue%0d: got valid=%b required 0", k, c_valid);
            end
        end
        fill_exp();
        pulse_start(1'b1);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL rstmid_rerun%0d: got valid=%b addr/data=%h required 1 %h",
                         k, c_valid, {c_addr, c_data}, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
    endtask

    task automatic test_back_to_back_start();
        logic [7:0] e;
        fill_exp();
        pulse_start(1'b1);
        for (int k = 0; k < 8; k++) begin
            start = (k == 2);
            e = exp_q.pop_front();
            checks++;
            if (c_valid !== 1'b1 || {c_addr, c_data} !== e) begin
                failures++;
                $display("FAIL restart_write%0d: got valid=%b addr/data=%h required 1 %h",
                         k, c_valid, {c_addr, c_data}, e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL restart_done: got d/b/v/e=%b%b%b%b required 1000", done, busy, c_valid, error);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, c_valid, error} !== 4'b1000) begin
            failures++;
            $display("FAIL restart_stays_done: got d/b/v/e=%b%b%b%b required 1000",
                     done, busy, c_valid, error);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        rst_n = 1'b1; start = 1'b0; c_ready = 1'b0;
        test_reset();
        test_full_sequence();
        test_stall();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid();
        test_back_to_back_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
